div_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative divider instance (WIDTH-bit, valid/busy interface) among NUM_REQ requesters, e.g. the x/z and y/z perspective divides in the AR projection pipeline. It accepts one request at a time, issues it to the divider and waits for the result. It then routes quotient, remainder and error back to the originating requester. It also bypasses divide-by-zero and watchdogs a hung divider.

---
 rtl/div_arb_pkg.sv | 21 ++
 rtl/div_arbiter_rr_picker.sv | 31 +++
 rtl/div_arbiter.sv | 173 +++++++++++++++++
 tb/tb_div_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM states, index width
// and the all-ones quotient used for bypass and watchdog completions.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned IDX_W     = $clog2(MAX_REQ);
  localparam int unsigned MAX_WIDTH = 32;

  // Mask of w low ones; w == MAX_WIDTH shifts everything out and yields all ones.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned w);
    return ~({MAX_WIDTH{1'b1}} << w);
  endfunction

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin select: first valid requester after last_i,
// wrapping around, so last_i itself has the lowest priority.
module rr_picker
  import div_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   grant_o
);

  always_comb begin
    int unsigned best_d;
    int unsigned d;
    any_o   = |req_i;
    grant_o = '0;
    best_d  = NUM_REQ;
    d       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Distance from the slot after last_i, modulo the ring size.
      d = (i + NUM_REQ - 32'(last_i) - 1) % NUM_REQ;
      if (req_i[i] && (d < best_d)) begin
        best_d  = d;
        grant_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one iterative divider among NUM_REQ requesters,
// with divide-by-zero bypass and a watchdog on the divider response.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       res_valid_out,
  output logic [WIDTH-1:0]         res_quotient_out,
  output logic [WIDTH-1:0]         res_remainder_out,
  output logic                     res_error_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_valid_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_valid_in,
  input  logic                     div_error_in,
  input  logic                     div_busy_in,
  output logic                     busy_out,
  output logic                     timeout_out
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [MAX_WIDTH-1:0] ONES_FULL = all_ones(WIDTH);
  localparam logic [WIDTH-1:0]     Q_ONES    = ONES_FULL[WIDTH-1:0];

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             accept;
  logic [WIDTH-1:0] sel_dvd, sel_dvs;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (req_valid_in),
    .last_i  (last_q),
    .any_o   (pick_any),
    .grant_o (pick_idx)
  );

  assign accept = (state_q == IDLE) && pick_any && !div_busy_in;

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        sel_dvd = req_dividend_in[i*WIDTH +: WIDTH];
        sel_dvs = req_divisor_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = pick_idx;
          dvd_d   = sel_dvd;
          dvs_d   = sel_dvs;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (dvs_q == '0) begin
          quo_d   = Q_ONES;
          rem_d   = dvd_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A result arriving on the expiry cycle takes precedence over the watchdog.
        if (div_valid_in) begin
          quo_d   = div_quotient_in;
          rem_d   = div_remainder_in;
          err_d   = div_error_in;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          quo_d   = Q_ONES;
          rem_d   = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_out = '0;
    res_valid_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && (IDX_W'(i) == pick_idx)) req_ready_out[i] = 1'b1;
      if ((state_q == DONE) && (IDX_W'(i) == grant_q)) res_valid_out[i] = 1'b1;
    end
    div_valid_out = (state_q == ISSUE) && (dvs_q != '0);
    busy_out      = (state_q != IDLE);
  end

  assign res_quotient_out  = quo_q;
  assign res_remainder_out = rem_q;
  assign res_error_out     = err_q;
  assign div_dividend_out  = dvd_q;
  assign div_divisor_out   = dvs_q;
  assign timeout_out       = tmo_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural iterative divider that
// can be switched into a never-responding mode to exercise the watchdog.
module tb_div_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 9;
  localparam int unsigned TMO  = 16;
  localparam int unsigned DLAT = 4;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic [N-1:0]   req_valid_in;
  logic [N*W-1:0] req_dividend_in;
  logic [N*W-1:0] req_divisor_in;
  logic [N-1:0]   req_ready_out;
  logic [N-1:0]   res_valid_out;
  logic [W-1:0]   res_quotient_out;
  logic [W-1:0]   res_remainder_out;
  logic           res_error_out;
  logic [W-1:0]   div_dividend_out;
  logic [W-1:0]   div_divisor_out;
  logic           div_valid_out;
  logic [W-1:0]   div_quotient_in;
  logic [W-1:0]   div_remainder_in;
  logic           div_valid_in;
  logic           div_error_in;
  logic           div_busy_in;
  logic           busy_out;
  logic           timeout_out;

  div_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_valid_in      (req_valid_in),
    .req_dividend_in   (req_dividend_in),
    .req_divisor_in    (req_divisor_in),
    .req_ready_out     (req_ready_out),
    .res_valid_out     (res_valid_out),
    .res_quotient_out  (res_quotient_out),
    .res_remainder_out (res_remainder_out),
    .res_error_out     (res_error_out),
    .div_dividend_out  (div_dividend_out),
    .div_divisor_out   (div_divisor_out),
    .div_valid_out     (div_valid_out),
    .div_quotient_in   (div_quotient_in),
    .div_remainder_in  (div_remainder_in),
    .div_valid_in      (div_valid_in),
    .div_error_in      (div_error_in),
    .div_busy_in       (div_busy_in),
    .busy_out          (busy_out),
    .timeout_out       (timeout_out)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    logic         tmo;
    int unsigned  cyc;
    int unsigned  lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_grant[$];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned n_divv = 0;
  int unsigned n_tmo = 0;
  int unsigned n_res = 0;
  int unsigned overlap = 0;

  logic [N-1:0] rv;
  logic [W-1:0] ra[N];
  logic [W-1:0] rb[N];
  int unsigned  reps[N];
  bit           acc[N];
  bit           hang = 1'b0;
  bit           stale_req = 1'b0;
  logic         dbusy;

  assign req_valid_in = rv;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_dividend_in[g*W +: W] = ra[g];
    assign req_divisor_in[g*W +: W]  = rb[g];
  end
  assign div_busy_in = dbusy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input int unsigned i, input int unsigned a, input int unsigned b,
                      input int unsigned n);
    ra[i]   = W'(a);
    rb[i]   = W'(b);
    reps[i] = n;
    rv[i]   = 1'b1;
  endtask

  task automatic wait_quiet(input int unsigned budget);
    int unsigned k = 0;
    while ((rv != '0 || sb.size() != 0 || busy_out) && k < budget) begin
      @(posedge clk_in);
      k++;
    end
    check("quiet_within_budget", 32'(k < budget), 32'd1);
    @(posedge clk_in);
    #2;
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Behavioural divider: DLAT busy cycles, then a one-cycle registered result.
  initial begin
    logic         s_v;
    logic [W-1:0] s_a, s_b, pa, pb;
    int unsigned  dcnt;
    div_valid_in = 1'b0; div_error_in = 1'b0; dbusy = 1'b0;
    div_quotient_in = '0; div_remainder_in = '0;
    dcnt = 0; pa = '0; pb = '1;
    forever begin
      @(negedge clk_in);
      s_v = div_valid_out; s_a = div_dividend_out; s_b = div_divisor_out;
      @(posedge clk_in);
      #1;
      div_valid_in = 1'b0;
      if (stale_req) begin
        stale_req        = 1'b0;
        div_valid_in     = 1'b1;
        div_quotient_in  = W'(123);
        div_remainder_in = W'(45);
      end else if (dbusy) begin
        if (dcnt == 1) begin
          dbusy            = 1'b0;
          div_valid_in     = 1'b1;
          div_quotient_in  = pa / pb;
          div_remainder_in = pa % pb;
          div_error_in     = 1'b0;
        end else dcnt--;
      end else if (s_v && !hang) begin
        dbusy = 1'b1;
        dcnt  = DLAT;
        pa    = s_a;
        pb    = s_b;
      end
    end
  end

  initial forever begin
    @(posedge clk_in);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        if (reps[i] > 0) reps[i]--;
        if (reps[i] == 0) rv[i] = 1'b0;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk_in);
    if (!rst_in) continue;
    for (int i = 0; i < N; i++) begin
      if (rv[i] && req_ready_out[i]) begin
        e.idx = i; e.a = ra[i]; e.b = rb[i]; e.cyc = cyc; e.tmo = 1'b0;
        if (rb[i] == '0) begin
          e.q = '1; e.r = ra[i]; e.err = 1'b1; e.lat = 2;
        end else if (hang) begin
          e.q = '1; e.r = '0; e.err = 1'b1; e.tmo = 1'b1; e.lat = TMO + 2;
        end else begin
          e.q = ra[i] / rb[i]; e.r = ra[i] % rb[i]; e.err = 1'b0; e.lat = DLAT + 3;
        end
        sb.push_back(e);
        acc[i] = 1'b1;
        if (exp_grant.size() > 0) check("grant_order", 32'(i), 32'(exp_grant.pop_front()));
      end
    end
    if (div_valid_out) begin
      n_divv++;
      if (dbusy) overlap++;
      if (sb.size() > 0) begin
        check("div_dividend", 32'(div_dividend_out), 32'(sb[0].a));
        check("div_divisor", 32'(div_divisor_out), 32'(sb[0].b));
      end
    end
    if (timeout_out) n_tmo++;
    if (res_valid_out != '0) begin
      n_res++;
      if (sb.size() == 0) check("unexpected_res", 32'(res_valid_out), 32'd0);
      else begin
        e = sb.pop_front();
        check("res_valid", 32'(res_valid_out), 32'd1 << e.idx);
        check("res_quotient", 32'(res_quotient_out), 32'(e.q));
        check("res_remainder", 32'(res_remainder_out), 32'(e.r));
        check("res_error", 32'(res_error_out), 32'(e.err));
        check("res_timeout", 32'(timeout_out), 32'(e.tmo));
        check("latency", cyc - e.cyc, e.lat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned t0, r0, d0;
    rv = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rb[i] = '0; reps[i] = 0; acc[i] = 1'b0;
    end
    repeat (3) @(posedge clk_in);
    #2;
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ready", 32'(req_ready_out), 32'd0);
    check("rst_res_valid", 32'(res_valid_out), 32'd0);
    check("rst_div_valid", 32'(div_valid_out), 32'd0);
    check("rst_quotient", 32'(res_quotient_out), 32'd0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #2;

    // single requester, real divider
    send(0, 64, 40, 1);
    wait_quiet(60);
    check("t1_q", 32'(res_quotient_out), 32'd1);
    check("t1_r", 32'(res_remainder_out), 32'd24);
    check("t1_err", 32'(res_error_out), 32'd0);

    // two simultaneous requesters
    exp_grant.push_back(1); exp_grant.push_back(2);
    send(1, 40, 4, 1);
    send(2, 100, 7, 1);
    wait_quiet(80);
    check("t2_q", 32'(res_quotient_out), 32'd14);
    check("t2_r", 32'(res_remainder_out), 32'd2);

    // divide by zero bypass
    d0 = n_divv;
    send(3, 77, 0, 1);
    wait_quiet(40);
    check("bypass_no_div", n_divv - d0, 32'd0);
    check("t4_q", 32'(res_quotient_out), 32'd511);
    check("t4_r", 32'(res_remainder_out), 32'd77);
    check("t4_err", 32'(res_error_out), 32'd1);

    // fairness with all four continuously valid
    for (int k = 0; k < 8; k++) exp_grant.push_back(k % N);
    for (int i = 0; i < N; i++) send(i, 10 + i * 50, i + 3, 2);
    wait_quiet(300);
    check("t3_grants_consumed", 32'(exp_grant.size()), 32'd0);

    // hung divider, watchdog, then a late response
    hang = 1'b1;
    t0 = n_tmo;
    send(1, 50, 3, 1);
    wait_quiet(80);
    check("t5_tmo_pulses", n_tmo - t0, 32'd1);
    check("t5_q", 32'(res_quotient_out), 32'd511);
    check("t5_r", 32'(res_remainder_out), 32'd0);
    check("t5_err", 32'(res_error_out), 32'd1);
    r0 = n_res;
    stale_req = 1'b1;
    repeat (6) @(posedge clk_in);
    #2;
    check("t5_stale_ignored", n_res - r0, 32'd0);
    check("t5_idle", 32'(busy_out), 32'd0);

    // reset in the middle of WAIT
    send(1, 90, 9, 1);
    repeat (6) @(posedge clk_in);
    #3;
    check("t6_in_wait", 32'(busy_out), 32'd1);
    rst_in = 1'b0;
    #1;
    check("t6_busy", 32'(busy_out), 32'd0);
    check("t6_res_valid", 32'(res_valid_out), 32'd0);
    check("t6_ready", 32'(req_ready_out), 32'd0);
    check("t6_div_valid", 32'(div_valid_out), 32'd0);
    check("t6_timeout", 32'(timeout_out), 32'd0);
    check("t6_quotient", 32'(res_quotient_out), 32'd0);
    check("t6_remainder", 32'(res_remainder_out), 32'd0);
    check("t6_error", 32'(res_error_out), 32'd0);
    check("t6_div_dividend", 32'(div_dividend_out), 32'd0);
    check("t6_div_divisor", 32'(div_divisor_out), 32'd0);
    sb.delete();
    exp_grant.delete();
    hang = 1'b0;
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    r0 = n_res;
    stale_req = 1'b1;
    repeat (4) @(posedge clk_in);
    #2;
    check("t6_stale_ignored", n_res - r0, 32'd0);
    for (int k = 0; k < N; k++) exp_grant.push_back(k);
    for (int i = 0; i < N; i++) send(i, 200 + i * 30, i + 5, 1);
    wait_quiet(200);
    check("t6_grants_consumed", 32'(exp_grant.size()), 32'd0);

    check("div_valid_overlap", overlap, 32'd0);
    check("total_timeouts", n_tmo, 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
